// File: rtl/edge_mon_pkg.sv
// -----------------------------------------------------------------------------
// edge_mon_pkg
//   Shared types, default parameters and helpers for edge_timeout_monitor.
//
//   mon_state_t : per-channel FSM state (IDLE / WAIT)
//   DEF_NUM_CH  : default number of monitored channels
//   DEF_CNT_W   : default width of timeout limit and cycle counters
//   MAX_CNT_W   : widest counter the helpers support (CNT_W must be <= this)
//   sat_limit() : maps a timeout of 0 to 1, passes all other values through
// -----------------------------------------------------------------------------
package edge_mon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mon_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_CNT_W  = 32;

    // A zero limit would never be reached by cnt+1, so it is treated as 1.
    function automatic logic [MAX_CNT_W-1:0] sat_limit(input logic [MAX_CNT_W-1:0] t);
        return (t == '0) ? MAX_CNT_W'(1) : t;
    endfunction

endpackage : edge_mon_pkg

// File: rtl/edge_timeout_ch.sv
// -----------------------------------------------------------------------------
// edge_timeout_ch
//   One monitored channel: waits after an arm pulse for an edge of the latched
//   polarity and reports either the cycle count (done) or a timeout.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   arm_i         : start / restart the wait; latches pos_i and timeout_i
//   pos_i         : polarity at arm (1 = rising, 0 = falling)
//   timeout_i     : limit at arm (0 behaves as 1)
//   rise_i/fall_i : edge strobes computed by the top from sig vs sig_q
//   state_o       : current FSM state (busy is derived from it)
//   done_o        : registered 1-cycle pulse, edge seen
//   timed_out_o   : registered 1-cycle pulse, limit reached without an edge
//   cycles_o      : result of the last completed wait, held until the next
// -----------------------------------------------------------------------------
module edge_timeout_ch
    import edge_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             pos_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             rise_i,
    input  logic             fall_i,
    output mon_state_t       state_o,
    output logic             done_o,
    output logic             timed_out_o,
    output logic [CNT_W-1:0] cycles_o
);

    mon_state_t       state_q, state_d;
    logic             pos_q, pos_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic             edge_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_limit;

    assign edge_hit = pos_q ? rise_i : fall_i;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    // cnt never exceeds limit-1, so cnt+1 cannot wrap.
    assign at_limit = (cnt_inc == limit_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pos_q    <= 1'b0;
            limit_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            limit_q  <= limit_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            to_q     <= to_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state logic: arm always (re)enters WAIT, even from WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arm_i) state_d = WAIT;
            WAIT: begin
                if (arm_i)                      state_d = WAIT;
                else if (edge_hit || at_limit)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. An edge beats the limit on the same posedge;
    // a restart suppresses any pulse for the aborted wait.
    always_comb begin
        pos_d    = pos_q;
        limit_d  = limit_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        to_d     = 1'b0;
        cycles_d = cycles_q;
        if (arm_i) begin
            pos_d   = pos_i;
            limit_d = CNT_W'(sat_limit(MAX_CNT_W'(timeout_i)));
            cnt_d   = '0;
        end else if (state_q == WAIT) begin
            if (edge_hit) begin
                done_d   = 1'b1;
                cycles_d = cnt_inc;
            end else if (at_limit) begin
                to_d     = 1'b1;
                cycles_d = limit_q;
            end else begin
                cnt_d    = cnt_inc;
            end
        end
    end

    assign state_o     = state_q;
    assign done_o      = done_q;
    assign timed_out_o = to_q;
    assign cycles_o    = cycles_q;

endmodule : edge_timeout_ch

// File: rtl/edge_timeout_monitor.sv
// -----------------------------------------------------------------------------
// edge_timeout_monitor
//   Watches NUM_CH independent signals. Each channel, once armed, waits for an
//   edge of the chosen polarity and reports the wait length or a timeout.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   sig           : monitored signals (synchronous to clk)
//   arm           : per-channel start/restart pulse
//   pos           : per-channel polarity, sampled at arm (1 rising, 0 falling)
//   timeout_clks  : limit shared by all channels, sampled at arm
//   err_clr       : clears the sticky error
//   busy          : channel is waiting
//   done          : 1-cycle pulse, edge seen
//   timed_out     : 1-cycle pulse, limit reached
//   cycles        : per-channel result, channel i at [i*CNT_W +: CNT_W]
//   err           : sticky, any timeout since last clear
//   first_err_vld, first_err_ch : only with EDGE_MON_FIRST_ERR_EN defined;
//                   index of the first channel to time out since rst/err_clr
//
// Result protocol: done/timed_out are single-cycle strobes with no back
// pressure; cycles for that channel is valid from the strobe cycle onward and
// holds until the channel's next completion.
//
// Optional feature macro: EDGE_MON_FIRST_ERR_EN
// -----------------------------------------------------------------------------
module edge_timeout_monitor
    import edge_mon_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       sig,
    input  logic [NUM_CH-1:0]       arm,
    input  logic [NUM_CH-1:0]       pos,
    input  logic [CNT_W-1:0]        timeout_clks,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       timed_out,
    output logic [NUM_CH*CNT_W-1:0] cycles,
    output logic                    err
`ifdef EDGE_MON_FIRST_ERR_EN
    ,
    output logic                    first_err_vld,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch
`endif
);

    logic [NUM_CH-1:0] sig_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    mon_state_t        ch_state [NUM_CH];
    logic              any_to;
    logic              err_q, err_d;

    // Edges are judged at each posedge from the live input vs last sample.
    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_timeout_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .arm_i       (arm[i]),
            .pos_i       (pos[i]),
            .timeout_i   (timeout_clks),
            .rise_i      (rise[i]),
            .fall_i      (fall[i]),
            .state_o     (ch_state[i]),
            .done_o      (done[i]),
            .timed_out_o (timed_out[i]),
            .cycles_o    (cycles[i*CNT_W +: CNT_W])
        );
        assign busy[i] = (ch_state[i] == WAIT);
    end

    assign any_to = |timed_out;
    // A timeout strobe sets err even when err_clr arrives in the same cycle.
    assign err_d  = any_to | (err_q & ~err_clr);
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
            err_q <= 1'b0;
        end else begin
            sig_q <= sig;
            err_q <= err_d;
        end
    end

`ifdef EDGE_MON_FIRST_ERR_EN
    localparam int FE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            fe_vld_q, fe_vld_d;
    logic [FE_W-1:0] fe_ch_q, fe_ch_d;
    logic [FE_W-1:0] low_ch;

    // Lowest-index channel among this cycle's timeouts.
    always_comb begin
        low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (timed_out[i]) low_ch = FE_W'(i);
        end
    end

    // Capture only when empty (or being cleared this cycle); hold otherwise.
    always_comb begin
        fe_vld_d = fe_vld_q;
        fe_ch_d  = fe_ch_q;
        if (err_clr) fe_vld_d = 1'b0;
        if (any_to && (!fe_vld_q || err_clr)) begin
            fe_vld_d = 1'b1;
            fe_ch_d  = low_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fe_vld_q <= 1'b0;
            fe_ch_q  <= '0;
        end else begin
            fe_vld_q <= fe_vld_d;
            fe_ch_q  <= fe_ch_d;
        end
    end

    assign first_err_vld = fe_vld_q;
    assign first_err_ch  = fe_ch_q;
`endif

endmodule : edge_timeout_monitor
